// File: rtl/uint16_digit_splitter_if.sv
// Request/digit-stream bundle for uint16_digit_splitter: conversion request,
// digit handshake and seven-segment drives.
interface uint16_digit_splitter_if;
    logic        start;
    logic [15:0] number;
    logic        busy;
    logic        digit_valid;
    logic        digit_ready;
    logic [3:0]  digit;
    logic        last;
    logic        top_left;
    logic        top;
    logic        top_right;
    logic        bottom_right;
    logic        bottom;
    logic        bottom_left;
    logic        middle;

    modport master (
        output start, number, digit_ready,
        input  busy, digit_valid, digit, last,
        input  top_left, top, top_right, bottom_right, bottom, bottom_left, middle
    );

    modport slave (
        input  start, number, digit_ready,
        output busy, digit_valid, digit, last,
        output top_left, top, top_right, bottom_right, bottom, bottom_left, middle
    );
endinterface

// File: rtl/uint16_digit_splitter.sv
// Splits a UInt16 into decimal digits (MS first, no leading zeros) via
// double-dabble, streaming them over valid/ready with a seven-segment decode.
module uint16_digit_splitter (
    input  logic                    clk,
    input  logic                    rst,
    uint16_digit_splitter_if.slave  bus
);
    localparam int unsigned IN_W   = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SEG_W  = 7;

    typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

    state_t              state_q, state_n;
    logic [IN_W-1:0]     shift_q, shift_n;
    logic [BCD_W-1:0]    bcd_q, bcd_n;
    logic [STEP_W-1:0]   step_q, step_n;
    logic [IDX_W-1:0]    index_q, index_n;
    logic [BCD_W+IN_W-1:0] shifted;
    logic [3:0]          digit_sel;
    logic                valid_c;
    logic [SEG_W-1:0]    seg_c;

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Highest nonzero nibble; 0 when all digits are zero so "0" still emits.
    function automatic logic [IDX_W-1:0] lead_index(input logic [BCD_W-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd0) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            bcd_q   <= bcd_n;
            step_q  <= step_n;
            index_q <= index_n;
        end
    end

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        bcd_n   = bcd_q;
        step_n  = step_q;
        index_n = index_q;
        shifted = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_n = bus.number;
                    bcd_n   = '0;
                    step_n  = '0;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                shifted          = {add3(bcd_q), shift_q} << 1;
                {bcd_n, shift_n} = shifted;
                step_n           = step_q + STEP_W'(1);
                if (step_q == STEP_W'(IN_W - 1)) begin
                    index_n = lead_index(bcd_n);
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (bus.digit_ready) begin
                    if (index_q == '0) state_n = IDLE;
                    else               index_n = index_q - IDX_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        digit_sel = 4'd0;
        case (index_q)
            3'd0:    digit_sel = bcd_q[3:0];
            3'd1:    digit_sel = bcd_q[7:4];
            3'd2:    digit_sel = bcd_q[11:8];
            3'd3:    digit_sel = bcd_q[15:12];
            3'd4:    digit_sel = bcd_q[19:16];
            default: digit_sel = 4'd0;
        endcase
    end

    // Segment order: top_left, top, top_right, bottom_right, bottom, bottom_left, middle.
    always_comb begin
        seg_c = '0;
        if (valid_c) begin
            case (digit_sel)
                4'd0:    seg_c = 7'b1111110;
                4'd1:    seg_c = 7'b0011000;
                4'd2:    seg_c = 7'b0110111;
                4'd3:    seg_c = 7'b0111101;
                4'd4:    seg_c = 7'b1011001;
                4'd5:    seg_c = 7'b1101101;
                4'd6:    seg_c = 7'b1101111;
                4'd7:    seg_c = 7'b0111000;
                4'd8:    seg_c = 7'b1111111;
                4'd9:    seg_c = 7'b1111101;
                default: seg_c = '0;
            endcase
        end
    end

    assign valid_c         = (state_q == EMIT);
    assign bus.busy        = (state_q != IDLE);
    assign bus.digit_valid = valid_c;
    assign bus.digit       = valid_c ? digit_sel : 4'd0;
    assign bus.last        = valid_c && (index_q == '0);
    assign {bus.top_left, bus.top, bus.top_right, bus.bottom_right,
            bus.bottom, bus.bottom_left, bus.middle} = seg_c;
endmodule
